// File: rtl/scrambler_datapath_3_if.sv
// Stream bundle for scrambler_datapath_3.
//   s_valid/s_data/s_ready : input word stream (producer -> scrambler)
//   m_valid/m_data/m_last/m_ready : scrambled word stream (scrambler -> consumer)
// Modports:
//   master : the side that produces s_* words and consumes m_* words
//   slave  : the scrambler itself
interface scrambler_datapath_3_if #(
    parameter int unsigned DATA_W = 13
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/scrambler_datapath_3.sv
// Frame-oriented stream scrambler. Each accepted DATA_W-bit word is XORed
// with the MSB-aligned top DATA_W bits of an external multi-step LFSR state,
// and the LFSR is told to advance once per accepted word.
// Optional feature macro: SCRAMBLER_BYPASS_EN (adds 'bypass' input; when set
// with start, words pass unmodified and the LFSR is never advanced).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : frame start pulse, honoured only in IDLE
//   frame_len    : frame length in words, sampled with start
//   lfsr_state   : registered LFSR state providing keystream
//   lfsr_enable  : combinational, advance LFSR on this edge
//   busy         : frame in progress (RUN/DRAIN)
//   done         : one-cycle pulse at frame completion
//   strm         : stream bundle (slave modport)
//   bypass       : (SCRAMBLER_BYPASS_EN only) pass-through for the frame
module scrambler_datapath_3 #(
    parameter int unsigned POLY_WIDTH = 347,
    parameter int unsigned DATA_W     = 13,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      frame_len,
    input  logic [POLY_WIDTH-1:0] lfsr_state,
`ifdef SCRAMBLER_BYPASS_EN
    input  logic                  bypass,
`endif
    output logic                  lfsr_enable,
    output logic                  busy,
    output logic                  done,
    scrambler_datapath_3_if.slave strm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic                done_d;
    logic                bypass_q;
    logic                s_ready_c;
    logic                accept_c;
    logic [DATA_W-1:0]   keystream_c;
    logic                m_valid_q;
    logic [DATA_W-1:0]   m_data_q;
    logic                m_last_q;

    // Only the top DATA_W bits of the LFSR state feed the keystream.
    logic lfsr_low_unused;
    assign lfsr_low_unused = ^lfsr_state[POLY_WIDTH-DATA_W-1:0];

`ifdef SCRAMBLER_BYPASS_EN
    // Bypass mode is latched at frame start and held for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_q <= 1'b0;
        end else if (state_q == ST_IDLE && start && frame_len != '0) begin
            bypass_q <= bypass;
        end
    end
`else
    assign bypass_q = 1'b0;
`endif

    // Handshake, keystream selection and LFSR advance.
    always_comb begin
        s_ready_c   = (state_q == ST_RUN) & (~m_valid_q | strm.m_ready);
        accept_c    = strm.s_valid & s_ready_c;
        keystream_c = bypass_q ? '0 : lfsr_state[POLY_WIDTH-1 -: DATA_W];
        lfsr_enable = accept_c & ~bypass_q;
    end

    // Next-state and frame counter logic.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (frame_len != '0) begin
                        state_d     = ST_RUN;
                        remaining_d = frame_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (m_valid_q && strm.m_ready && m_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; busy is registered from the next state so it tracks state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done        <= done_d;
            busy        <= (state_d != ST_IDLE);
        end
    end

    // Output register stage: loads on accept, otherwise holds until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else if (accept_c) begin
            m_valid_q <= 1'b1;
            m_data_q  <= strm.s_data ^ keystream_c;
            m_last_q  <= (remaining_q == LEN_W'(1));
        end else if (m_valid_q && strm.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign strm.s_ready = s_ready_c;
    assign strm.m_valid = m_valid_q;
    assign strm.m_data  = m_data_q;
    assign strm.m_last  = m_last_q;

endmodule

// File: tb/tb_scrambler_datapath_3.sv
// Directed self-checking bench for scrambler_datapath_3.
// The LFSR is stood in for by a rotate-by-DATA_W register: any linear
// shift register stays all-zero from an all-zero seed, and rotation makes the
// keystream of word k simply the k-th 13-bit field of the seed.
module tb_scrambler_datapath_3;
    localparam int unsigned POLY_WIDTH = 347;
    localparam int unsigned DATA_W     = 13;
    localparam int unsigned LEN_W      = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [LEN_W-1:0]      frame_len;
    logic [POLY_WIDTH-1:0] lfsr_q;
    logic [POLY_WIDTH-1:0] csr_seed;
    logic                  csr_load;
    logic                  lfsr_enable;
    logic                  busy;
    logic                  done;
`ifdef SCRAMBLER_BYPASS_EN
    logic                  bypass;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;

    logic [DATA_W-1:0] in_w  [4];
    logic [DATA_W-1:0] exp_w [4];

    scrambler_datapath_3_if #(.DATA_W(DATA_W)) bus ();

    scrambler_datapath_3 #(
        .POLY_WIDTH (POLY_WIDTH),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .frame_len   (frame_len),
        .lfsr_state  (lfsr_q),
`ifdef SCRAMBLER_BYPASS_EN
        .bypass      (bypass),
`endif
        .lfsr_enable (lfsr_enable),
        .busy        (busy),
        .done        (done),
        .strm        (bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in LFSR: CSR load in IDLE, advance DATA_W steps per enable.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= '0;
        end else if (csr_load) begin
            lfsr_q <= csr_seed;
        end else if (lfsr_enable) begin
            lfsr_q <= {lfsr_q[POLY_WIDTH-DATA_W-1:0], lfsr_q[POLY_WIDTH-1 -: DATA_W]};
        end
    end

    always @(posedge clk) begin
        if (lfsr_enable) en_cnt <= en_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [POLY_WIDTH-1:0] got,
                            input logic [POLY_WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_seed(input logic [POLY_WIDTH-1:0] seed);
        @(negedge clk);
        csr_seed = seed;
        csr_load = 1'b1;
        @(negedge clk);
        csr_load = 1'b0;
    endtask

    // Streams n words from in_w with m_ready held high and checks against exp_w.
    task automatic run_stream(input int n, input logic en_exp, input string tag);
        int en0;
        @(negedge clk);
        start     = 1'b1;
        frame_len = LEN_W'(n);
        @(negedge clk);
        start       = 1'b0;
        bus.m_ready = 1'b1;
        check_eq({tag, ":busy"}, POLY_WIDTH'(busy), POLY_WIDTH'(1));
        en0 = en_cnt;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                check_eq($sformatf("%s:m_valid[%0d]", tag, i-1), POLY_WIDTH'(bus.m_valid), POLY_WIDTH'(1));
                check_eq($sformatf("%s:m_data[%0d]", tag, i-1), POLY_WIDTH'(bus.m_data), POLY_WIDTH'(exp_w[i-1]));
                check_eq($sformatf("%s:m_last[%0d]", tag, i-1), POLY_WIDTH'(bus.m_last), POLY_WIDTH'(i == n));
            end
            if (i < n) begin
                bus.s_valid = 1'b1;
                bus.s_data  = in_w[i];
                #1;
                check_eq($sformatf("%s:s_ready[%0d]", tag, i), POLY_WIDTH'(bus.s_ready), POLY_WIDTH'(1));
                check_eq($sformatf("%s:lfsr_en[%0d]", tag, i), POLY_WIDTH'(lfsr_enable), POLY_WIDTH'(en_exp));
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = '0;
                #1;
                check_eq({tag, ":lfsr_en_drain"}, POLY_WIDTH'(lfsr_enable), POLY_WIDTH'(0));
            end
            @(negedge clk);
        end
        check_eq({tag, ":done"}, POLY_WIDTH'(done), POLY_WIDTH'(1));
        check_eq({tag, ":m_valid_end"}, POLY_WIDTH'(bus.m_valid), POLY_WIDTH'(0));
        check_eq({tag, ":busy_end"}, POLY_WIDTH'(busy), POLY_WIDTH'(0));
        check_eq({tag, ":en_count"}, POLY_WIDTH'(en_cnt - en0), en_exp ? POLY_WIDTH'(n) : POLY_WIDTH'(0));
        @(negedge clk);
        check_eq({tag, ":done_pulse"}, POLY_WIDTH'(done), POLY_WIDTH'(0));
    endtask

    initial begin
        logic [POLY_WIDTH-1:0] seed3;
        logic [DATA_W-1:0]     t3_md [10];
        logic                  t3_last [10];
        logic                  t3_sr [10];
        int                    en0;
        int                    wi;

        rst         = 1'b1;
        start       = 1'b0;
        frame_len   = '0;
        csr_seed    = '0;
        csr_load    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
`ifdef SCRAMBLER_BYPASS_EN
        bypass      = 1'b0;
`endif
        seed3 = '0;
        seed3[POLY_WIDTH-1 -: 3*DATA_W] = {13'h1A5A, 13'h0123, 13'h1FFF};

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst:m_valid", POLY_WIDTH'(bus.m_valid), POLY_WIDTH'(0));
        check_eq("rst:m_data", POLY_WIDTH'(bus.m_data), POLY_WIDTH'(0));
        check_eq("rst:m_last", POLY_WIDTH'(bus.m_last), POLY_WIDTH'(0));
        check_eq("rst:done", POLY_WIDTH'(done), POLY_WIDTH'(0));
        check_eq("rst:busy", POLY_WIDTH'(busy), POLY_WIDTH'(0));
        check_eq("rst:s_ready", POLY_WIDTH'(bus.s_ready), POLY_WIDTH'(0));
        rst = 1'b0;

        // 1: single word, keystream 1A5A: 0F0F ^ 1A5A = 1555
        load_seed(seed3);
        in_w[0]  = 13'h0F0F;
        exp_w[0] = 13'h1555;
        run_stream(1, 1'b1, "t1");

        // 2: all-zero LFSR, four words pass through unchanged
        load_seed('0);
        in_w  = '{13'h0001, 13'h1FFF, 13'h0AAA, 13'h1234};
        exp_w = in_w;
        run_stream(4, 1'b1, "t2");

        // 3: len=3 with m_ready pattern 1,0,0,1,...
        load_seed(seed3);
        in_w    = '{13'h0F0F, 13'h1000, 13'h0555, 13'h0000};
        t3_md   = '{13'h0000, 13'h1555, 13'h1555, 13'h1555, 13'h1123,
                    13'h1123, 13'h1123, 13'h1AAA, 13'h1AAA, 13'h1AAA};
        t3_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        t3_sr   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        start     = 1'b1;
        frame_len = LEN_W'(3);
        @(negedge clk);
        start = 1'b0;
        en0   = en_cnt;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                check_eq($sformatf("t3:m_valid[c%0d]", c), POLY_WIDTH'(bus.m_valid), POLY_WIDTH'(1));
                check_eq($sformatf("t3:m_data[c%0d]", c), POLY_WIDTH'(bus.m_data), POLY_WIDTH'(t3_md[c]));
                check_eq($sformatf("t3:m_last[c%0d]", c), POLY_WIDTH'(bus.m_last), POLY_WIDTH'(t3_last[c]));
            end
            wi = (c == 0) ? 0 : (c <= 3) ? 1 : 2;
            bus.m_ready = (c % 3 == 0);
            bus.s_valid = (c < 7);
            bus.s_data  = (c < 7) ? in_w[wi] : '0;
            #1;
            check_eq($sformatf("t3:s_ready[c%0d]", c), POLY_WIDTH'(bus.s_ready), POLY_WIDTH'(t3_sr[c]));
            check_eq($sformatf("t3:lfsr_en[c%0d]", c), POLY_WIDTH'(lfsr_enable), POLY_WIDTH'(t3_sr[c]));
            @(negedge clk);
        end
        check_eq("t3:done", POLY_WIDTH'(done), POLY_WIDTH'(1));
        check_eq("t3:m_valid_end", POLY_WIDTH'(bus.m_valid), POLY_WIDTH'(0));
        check_eq("t3:en_count", POLY_WIDTH'(en_cnt - en0), POLY_WIDTH'(3));
        bus.m_ready = 1'b1;

        // 4: zero-length frame
        en0 = en_cnt;
        @(negedge clk);
        start     = 1'b1;
        frame_len = '0;
        @(negedge clk);
        start = 1'b0;
        check_eq("t4:done", POLY_WIDTH'(done), POLY_WIDTH'(1));
        check_eq("t4:busy", POLY_WIDTH'(busy), POLY_WIDTH'(0));
        @(negedge clk);
        check_eq("t4:done_pulse", POLY_WIDTH'(done), POLY_WIDTH'(0));
        check_eq("t4:busy2", POLY_WIDTH'(busy), POLY_WIDTH'(0));
        check_eq("t4:en_count", POLY_WIDTH'(en_cnt - en0), POLY_WIDTH'(0));

        // 5: reset after two of five words, then a clean len=2 frame
        load_seed('0);
        @(negedge clk);
        start     = 1'b1;
        frame_len = LEN_W'(5);
        @(negedge clk);
        start       = 1'b0;
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 13'h0011;
        @(negedge clk);
        bus.s_data  = 13'h0022;
        @(negedge clk);
        check_eq("t5:m_valid_pre", POLY_WIDTH'(bus.m_valid), POLY_WIDTH'(1));
        check_eq("t5:m_data_pre", POLY_WIDTH'(bus.m_data), POLY_WIDTH'(13'h0022));
        rst = 1'b1;
        #1;
        check_eq("t5:m_valid_rst", POLY_WIDTH'(bus.m_valid), POLY_WIDTH'(0));
        check_eq("t5:busy_rst", POLY_WIDTH'(busy), POLY_WIDTH'(0));
        check_eq("t5:done_rst", POLY_WIDTH'(done), POLY_WIDTH'(0));
        @(negedge clk);
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("t5:no_done", POLY_WIDTH'(done), POLY_WIDTH'(0));
        end
        in_w[0]  = 13'h0ABC;
        in_w[1]  = 13'h1DEF;
        exp_w[0] = 13'h0ABC;
        exp_w[1] = 13'h1DEF;
        run_stream(2, 1'b1, "t5b");

`ifdef SCRAMBLER_BYPASS_EN
        // 6: bypass frame leaves words and LFSR state untouched
        load_seed(seed3);
        bypass   = 1'b1;
        in_w[0]  = 13'h0F0F;
        in_w[1]  = 13'h1000;
        exp_w[0] = 13'h0F0F;
        exp_w[1] = 13'h1000;
        run_stream(2, 1'b0, "t6");
        bypass = 1'b0;
        check_eq("t6:lfsr_kept", lfsr_q, seed3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
